// File: rtl/cpu_step_clock_pkg.sv
// cpu_step_clock_pkg
// Shared types and constants for the single-step processor clock generator.
//   dbState_t    : pushbutton debounce FSM states
//   pulseState_t : cpu_clk pulse FSM states
//   STEP_CNT_W   : width of the step counter
package cpu_step_clock_pkg;

  localparam int STEP_CNT_W = 16;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } dbState_t;

  typedef enum logic [1:0] {
    PL_LOW,
    PL_HIGH,
    PL_GAP
  } pulseState_t;

endpackage

// File: rtl/cpu_step_clock_if.sv
// cpu_step_clock_if
// Groups the board-side controls and processor-clock outputs.
//   btn_step   : raw pushbutton, 1 = pressed (asynchronous)
//   sw_run     : raw run switch, 1 = free-run (asynchronous)
//   halt       : clk-synchronous step inhibit
//   cpu_clk    : generated processor clock
//   step_count : number of cpu_clk rising edges since reset (saturating)
//   busy       : a pulse (high or minimum low phase) is in progress
// master drives the controls, slave is the clock generator.
interface cpu_step_clock_if;
  import cpu_step_clock_pkg::*;

  logic                  btn_step;
  logic                  sw_run;
  logic                  halt;
  logic                  cpu_clk;
  logic [STEP_CNT_W-1:0] step_count;
  logic                  busy;

  modport master (
    output btn_step, sw_run, halt,
    input  cpu_clk, step_count, busy
  );

  modport slave (
    input  btn_step, sw_run, halt,
    output cpu_clk, step_count, busy
  );
endinterface

// File: rtl/cpu_step_clock_btn_debounce.sv
// btn_debounce
// Two-flop synchronizer plus debounce FSM for one pushbutton. A level is
// accepted only after DEBOUNCE_CYCLES consecutive identical synced samples.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btnRaw     : raw asynchronous button input
//   press      : one-cycle pulse on entry into the pressed state
module btn_debounce
  import cpu_step_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnRaw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       syncP;
  logic             btnSync;
  dbState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             pressNext;

  assign btnSync = syncP[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncP <= '0;
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      syncP <= {syncP[0], btnRaw};
      state <= stateNext;
      cnt   <= cntNext;
      press <= pressNext;
    end
  end

  // The counter tracks consecutive samples of the level being confirmed;
  // any contrary sample drops back and clears it.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pressNext = 1'b0;
    case (state)
      DB_IDLE: begin
        cntNext = '0;
        if (btnSync) stateNext = DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT: begin
        if (!btnSync) begin
          stateNext = DB_IDLE;
          cntNext   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = DB_PRESSED;
          cntNext   = '0;
          pressNext = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DB_PRESSED: begin
        cntNext = '0;
        if (!btnSync) stateNext = DB_RELEASE_WAIT;
      end
      DB_RELEASE_WAIT: begin
        if (btnSync) begin
          stateNext = DB_PRESSED;
          cntNext   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = DB_IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        stateNext = DB_IDLE;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_step_clock.sv
// cpu_step_clock
// Generates a processor clock one pulse at a time from a debounced
// pushbutton, or periodically in free-run mode.
// Optional feature: define STEP_CLOCK_AUTORUN_EN to enable sw_run free-run
// mode with a RUN_DIV step interval; otherwise sw_run is ignored.
// Ports:
//   clk, rst_n : board clock, asynchronous active-low reset
//   io         : cpu_step_clock_if.slave (btn_step, sw_run, halt in;
//                cpu_clk, step_count, busy out)
module cpu_step_clock
  import cpu_step_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int RUN_DIV         = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_step_clock_if.slave    io
);

  localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

  function automatic logic [STEP_CNT_W-1:0] satInc(input logic [STEP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic btnPress;
  logic stepReq;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uBtnDebounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btnRaw (io.btn_step),
    .press  (btnPress)
  );

`ifdef STEP_CLOCK_AUTORUN_EN
  localparam int RCNT_W = $clog2(RUN_DIV + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RUN_DIV - 1);

  logic [1:0]        runSyncP;
  logic              runSync;
  logic [RCNT_W-1:0] runCnt;
  logic              runTick;

  assign runSync = runSyncP[1];
  assign runTick = runSync && (runCnt == RCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runSyncP <= '0;
      runCnt   <= '0;
    end else begin
      runSyncP <= {runSyncP[0], io.sw_run};
      if (!runSync || runTick) runCnt <= '0;
      else                     runCnt <= runCnt + 1'b1;
    end
  end

  // The button is ignored entirely while free-running.
  assign stepReq = runSync ? runTick : btnPress;
`else
  logic unusedSwRun;
  assign unusedSwRun = io.sw_run;
  assign stepReq     = btnPress;
`endif

  pulseState_t           pulse, pulseNext;
  logic [PCNT_W-1:0]     pcnt, pcntNext;
  logic [STEP_CNT_W-1:0] stepCount, stepCountNext;
  logic                  cpuClkQ, busyQ;

  // Pulse state, phase counter and the registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse     <= PL_LOW;
      pcnt      <= '0;
      stepCount <= '0;
      cpuClkQ   <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      pulse     <= pulseNext;
      pcnt      <= pcntNext;
      stepCount <= stepCountNext;
      cpuClkQ   <= (pulseNext == PL_HIGH);
      busyQ     <= (pulseNext != PL_LOW);
    end
  end

  // Requests are only looked at in LOW; anything arriving during HIGH/GAP is
  // dropped, and halt cannot cut short a pulse already started.
  always_comb begin
    pulseNext     = pulse;
    pcntNext      = pcnt;
    stepCountNext = stepCount;
    case (pulse)
      PL_LOW: begin
        pcntNext = '0;
        if (stepReq && !io.halt) begin
          pulseNext     = PL_HIGH;
          stepCountNext = satInc(stepCount);
        end
      end
      PL_HIGH: begin
        if (pcnt == PCNT_LAST) begin
          pulseNext = PL_GAP;
          pcntNext  = '0;
        end else begin
          pcntNext = pcnt + 1'b1;
        end
      end
      PL_GAP: begin
        if (pcnt == PCNT_LAST) begin
          pulseNext = PL_LOW;
          pcntNext  = '0;
        end else begin
          pcntNext = pcnt + 1'b1;
        end
      end
      default: begin
        pulseNext = PL_LOW;
        pcntNext  = '0;
      end
    endcase
  end

  assign io.cpu_clk    = cpuClkQ;
  assign io.busy       = busyQ;
  assign io.step_count = stepCount;

endmodule

// File: doc/cpu_step_clock.md
CPU_STEP_CLOCK -- requirements
Module: cpu_step_clock

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000; consecutive stable clk cycles needed to accept a button level (20 ms at 50 MHz).
REQ-002 Parameter PULSE_CYCLES, default 4; clk cycles cpu_clk stays high per step, and the minimum low time between steps.
REQ-003 Parameter RUN_DIV, default 25000000; clk cycles between automatic steps in run mode.
REQ-004 Port clk, input, 1; board clock. One clock; reset is asynchronous and active-low.
REQ-005 Port rst_n, input, 1; asynchronous active-low reset.
REQ-006 Port btn_step, input, 1; raw pushbutton, asynchronous, 1 = pressed.
REQ-007 Port sw_run, input, 1; raw switch, asynchronous, 1 = free-run mode.
REQ-008 Port halt, input, 1; synchronous to clk, 1 = inhibit new steps.
REQ-009 Port cpu_clk, output, 1; registered processor clock; one high pulse per step.
REQ-010 Port step_count, output, 16; number of cpu_clk rising edges since reset.
REQ-011 Port busy, output, 1; 1 while a pulse (high phase or minimum low phase) is in progress.

Function
REQ-012 btn_step and sw_run each pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE -> PRESS_WAIT on synced btn=1; PRESS_WAIT -> PRESSED after DEBOUNCE_CYCLES consecutive 1s, else back to IDLE on any 0 (counter clears).
REQ-015 PRESSED -> RELEASE_WAIT on btn=0; RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive 0s, else back to PRESSED on any 1.
REQ-016 Entry into PRESSED raises a one-cycle step request; a held button yields exactly one step.
REQ-017 Pulse FSM states: LOW, HIGH, GAP; cpu_clk = 1 only in HIGH.
REQ-018 A step request accepted in LOW with halt=0 makes cpu_clk rise on the next clk edge; HIGH lasts PULSE_CYCLES cycles, GAP lasts PULSE_CYCLES cycles, then LOW.
REQ-019 Step requests arriving while busy=1 or halt=1 are dropped, not queued.
REQ-020 halt asserted during HIGH or GAP does not truncate the pulse in progress.
REQ-021 In run mode, a free counter issues a step request every RUN_DIV cycles; the button step request is ignored while run mode is active.
REQ-022 Leaving run mode mid-pulse completes the pulse; the run counter clears to 0 whenever run mode is inactive.
REQ-023 step_count increments on the clk edge where cpu_clk goes 0->1 and saturates at 16'hFFFF.
REQ-024 cpu_clk is driven directly from a flop; it has no combinational path from any input.

Reset
REQ-025 rst_n=0 forces asynchronously: cpu_clk=0, busy=0, step_count=0, both FSMs to IDLE/LOW, all counters and synchronizers to 0, including mid-pulse.
REQ-026 After reset release, a button already held must still complete the PRESS_WAIT debounce before a step is issued.

Configuration
REQ-027 Macro STEP_CLOCK_AUTORUN_EN defined: sw_run and the RUN_DIV counter are present per REQ-021/022.
REQ-028 Macro undefined: the sw_run synchronizer and run counter are absent, sw_run is ignored, and steps come only from the button.

Structure
REQ-029 A shared package holds the debounce and pulse state enums and the step_count width constant (16).
REQ-030 One sub-module, btn_debounce (synchronizer + REQ-013..016 FSM, one-cycle press output), instantiated once for btn_step.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, RUN_DIV=10)
REQ-031 btn held 20 cycles -> exactly one cpu_clk pulse, 2 cycles high, step_count=1.
REQ-032 btn glitches of 1-3 cycles, repeated -> no pulse, step_count=0.
REQ-033 sw_run=1 for 100 cycles -> cpu_clk rises every 10 cycles, step_count=10 (+/-1 for sync latency); btn presses meanwhile add none.
REQ-034 halt=1 with btn press -> no pulse; halt=1 raised during HIGH -> pulse still completes 2 high cycles.
REQ-035 rst_n=0 during HIGH -> cpu_clk=0 same cycle, step_count=0, busy=0.
REQ-036 Force step_count to 16'hFFFE then give 3 steps -> holds at 16'hFFFF.
